// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : State encoding, RV32I opcodes and datapath select encodings
//            shared by the multicycle control FSM.
//            Optional macro: MULTICYCLE_MAIN_FSM_MULDIV_EN adds the MULDIV state.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXER   = 4'd6,
    S_EXEI   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_UPPER  = 4'd12,
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
    S_TRAP   = 4'd13,
    S_MULDIV = 4'd14
`else
    S_TRAP   = 4'd13
`endif
  } state_t;

  // RV32I major opcodes
  localparam logic [6:0] c_OP_LW    = 7'b0000011;
  localparam logic [6:0] c_OP_SW    = 7'b0100011;
  localparam logic [6:0] c_OP_R     = 7'b0110011;
  localparam logic [6:0] c_OP_I     = 7'b0010011;
  localparam logic [6:0] c_OP_B     = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  // ResultSrc
  localparam logic [1:0] c_RES_ALUOUT = 2'b00;
  localparam logic [1:0] c_RES_DATA   = 2'b01;
  localparam logic [1:0] c_RES_ALU    = 2'b10;
  localparam logic [1:0] c_RES_MULDIV = 2'b11;

  // ALUSrcA
  localparam logic [1:0] c_SRCA_PC    = 2'b00;
  localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
  localparam logic [1:0] c_SRCA_RS1   = 2'b10;
  localparam logic [1:0] c_SRCA_ZERO  = 2'b11;

  // ALUSrcB
  localparam logic [1:0] c_SRCB_RS2  = 2'b00;
  localparam logic [1:0] c_SRCB_IMM  = 2'b01;
  localparam logic [1:0] c_SRCB_FOUR = 2'b10;

  // ALUOp class
  localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

  // ImmSrc formats
  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_J = 3'b011;
  localparam logic [2:0] c_IMM_U = 3'b100;

  // Immediate format is a pure function of the opcode; unknown ops use I.
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      c_OP_SW:              imm_src = c_IMM_S;
      c_OP_B:               imm_src = c_IMM_B;
      c_OP_JAL:             imm_src = c_IMM_J;
      c_OP_LUI, c_OP_AUIPC: imm_src = c_IMM_U;
      default:              imm_src = c_IMM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_timer
// Brief    : Counts consecutive memory wait cycles and flags the cycle in
//            which the wait budget is exhausted.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int WCNT_W      = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  output logic expired
);

  logic [WCNT_W-1:0] r_count;

  // Last permitted wait cycle: the FSM redirects to TRAP on this one.
  assign expired = waiting && (r_count == WCNT_W'(MEM_TIMEOUT - 1));

  // Count while stalled; any exit from waiting (ready, timeout, leave state) clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (waiting && !expired) begin
      r_count <= r_count + WCNT_W'(1);
    end else begin
      r_count <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_fsm
// Brief    : Main control FSM of a multicycle RV32I core with memory
//            wait-state timeout and illegal-opcode trap.
//            Optional macro: MULTICYCLE_MAIN_FSM_MULDIV_EN (M-extension handshake).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int WCNT_W      = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
  input  logic       funct7_0,
  input  logic       muldiv_done,
  output logic       muldiv_start,
`endif
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       Branch,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       illegal_instr,
  output logic       bus_fault
);

  state_t r_state;
  state_t w_next;
  logic   r_bus_cause;
  logic   r_jalr_ph;
  logic   w_waiting;
  logic   w_expired;

  logic       w_mem_req, w_pcwrite, w_adrsrc, w_memwrite, w_irwrite;
  logic       w_regwrite, w_branch, w_illegal, w_bus_fault;
  logic [1:0] w_resultsrc, w_alusrca, w_alusrcb, w_aluop;

`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
  logic r_md_started;
  logic r_md_result;
  logic w_muldiv_start;
`endif

  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMRD) ||
                      (r_state == S_MEMWR)) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .WCNT_W      (WCNT_W)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (w_waiting),
    .expired (w_expired)
  );

  // State register plus the small amount of side state the Moore outputs need.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_bus_cause <= 1'b0;
      r_jalr_ph   <= 1'b0;
    end else begin
      r_state     <= w_next;
      // TRAP is entered either from a timeout (bus) or from DECODE (illegal).
      r_bus_cause <= w_expired;
      r_jalr_ph   <= (r_state == S_JALR) && !r_jalr_ph;
    end
  end

`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
  // Track first MULDIV cycle (start pulse) and route the unit's result in ALUWB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_started <= 1'b0;
      r_md_result  <= 1'b0;
    end else begin
      r_md_started <= (r_state == S_MULDIV) && (w_next == S_MULDIV);
      r_md_result  <= (r_state == S_MULDIV);
    end
  end
`endif

  // Next-state and datapath controls; everything defaults to idle.
  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_pcwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    w_bus_fault = 1'b0;
    w_resultsrc = c_RES_ALUOUT;
    w_alusrca   = c_SRCA_PC;
    w_alusrcb   = c_SRCB_RS2;
    w_aluop     = c_ALUOP_ADD;
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
    w_muldiv_start = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_alusrcb = c_SRCB_FOUR;
        if (mem_ready) begin
          w_irwrite   = 1'b1;
          w_pcwrite   = 1'b1;
          w_resultsrc = c_RES_ALU;
          w_next      = S_DECODE;
        end
      end
      S_DECODE: begin
        w_alusrca = c_SRCA_OLDPC;
        w_alusrcb = c_SRCB_IMM;
        case (op)
          c_OP_LW, c_OP_SW:     w_next = S_MEMADR;
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
          c_OP_R:               w_next = funct7_0 ? S_MULDIV : S_EXER;
`else
          c_OP_R:               w_next = S_EXER;
`endif
          c_OP_I:               w_next = S_EXEI;
          c_OP_B:               w_next = S_BRANCH;
          c_OP_JAL:             w_next = S_JAL;
          c_OP_JALR:            w_next = S_JALR;
          c_OP_LUI, c_OP_AUIPC: w_next = S_UPPER;
          default:              w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = c_SRCA_RS1;
        w_alusrcb = c_SRCB_IMM;
        w_next    = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adrsrc  = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_MEMWB: begin
        w_regwrite  = 1'b1;
        w_resultsrc = c_RES_DATA;
        w_next      = S_FETCH;
      end
      S_EXER, S_EXEI: begin
        w_alusrca = c_SRCA_RS1;
        w_alusrcb = (r_state == S_EXEI) ? c_SRCB_IMM : c_SRCB_RS2;
        w_aluop   = c_ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
        w_resultsrc = r_md_result ? c_RES_MULDIV : c_RES_ALUOUT;
`endif
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_alusrca = c_SRCA_RS1;
        w_alusrcb = c_SRCB_RS2;
        w_aluop   = c_ALUOP_SUB;
        w_branch  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        // PC <- branch target latched in DECODE; ALU forms the link PC+4.
        w_alusrca = c_SRCA_OLDPC;
        w_alusrcb = c_SRCB_FOUR;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        if (!r_jalr_ph) begin
          // Phase 0: compute rs1 + imm into ALUOut as the jump target.
          w_alusrca = c_SRCA_RS1;
          w_alusrcb = c_SRCB_IMM;
        end else begin
          w_alusrca = c_SRCA_OLDPC;
          w_alusrcb = c_SRCB_FOUR;
          w_pcwrite = 1'b1;
          w_next    = S_ALUWB;
        end
      end
      S_UPPER: begin
        w_alusrca = (op == c_OP_LUI) ? c_SRCA_ZERO : c_SRCA_OLDPC;
        w_alusrcb = c_SRCB_IMM;
        w_next    = S_ALUWB;
      end
      S_TRAP: begin
        w_illegal   = !r_bus_cause;
        w_bus_fault = r_bus_cause;
        w_next      = S_FETCH;
      end
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
      S_MULDIV: begin
        w_muldiv_start = !r_md_started;
        if (muldiv_done) w_next = S_ALUWB;
      end
`endif
      default: w_next = S_FETCH;
    endcase
    // A stalled memory state whose budget ran out is redirected to TRAP.
    if (w_expired) w_next = S_TRAP;
  end

  // Every output is forced low while reset is asserted.
  assign mem_req       = rst_n & w_mem_req;
  assign PCWrite       = rst_n & w_pcwrite;
  assign AdrSrc        = rst_n & w_adrsrc;
  assign MemWrite      = rst_n & w_memwrite;
  assign IRWrite       = rst_n & w_irwrite;
  assign RegWrite      = rst_n & w_regwrite;
  assign Branch        = rst_n & w_branch;
  assign ResultSrc     = {2{rst_n}} & w_resultsrc;
  assign ALUSrcA       = {2{rst_n}} & w_alusrca;
  assign ALUSrcB       = {2{rst_n}} & w_alusrcb;
  assign ALUOp         = {2{rst_n}} & w_aluop;
  assign ImmSrc        = {3{rst_n}} & imm_src(op);
  assign illegal_instr = rst_n & w_illegal;
  assign bus_fault     = rst_n & w_bus_fault;
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
  assign muldiv_start  = rst_n & w_muldiv_start;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_main_fsm
// Brief    : Directed self-checking bench for multicycle_main_fsm
//            (MEM_TIMEOUT = 4), expected control vectors queued per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_fsm;

  localparam logic [6:0] c_LW    = 7'b0000011;
  localparam logic [6:0] c_SW    = 7'b0100011;
  localparam logic [6:0] c_R     = 7'b0110011;
  localparam logic [6:0] c_I     = 7'b0010011;
  localparam logic [6:0] c_B     = 7'b1100011;
  localparam logic [6:0] c_JAL   = 7'b1101111;
  localparam logic [6:0] c_JALR  = 7'b1100111;
  localparam logic [6:0] c_LUI   = 7'b0110111;
  localparam logic [6:0] c_AUIPC = 7'b0010111;
  localparam logic [6:0] c_BAD   = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       mem_ready;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Branch;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       illegal_instr, bus_fault;
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
  logic       funct7_0 = 1'b0;
  logic       muldiv_done = 1'b0;
  logic       muldiv_start;
`endif

  int total = 0;
  int bad   = 0;

  logic [19:0] q_exp[$];
  string       q_tag[$];

  always #5 clk = ~clk;

  multicycle_main_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .mem_ready     (mem_ready),
`ifdef MULTICYCLE_MAIN_FSM_MULDIV_EN
    .funct7_0      (funct7_0),
    .muldiv_done   (muldiv_done),
    .muldiv_start  (muldiv_start),
`endif
    .mem_req       (mem_req),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .Branch        (Branch),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .ImmSrc        (ImmSrc),
    .illegal_instr (illegal_instr),
    .bus_fault     (bus_fault)
  );

  // Expected immediate format table.
  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      c_SW:           imm_of = 3'b001;
      c_B:            imm_of = 3'b010;
      c_JAL:          imm_of = 3'b011;
      c_LUI, c_AUIPC: imm_of = 3'b100;
      default:        imm_of = 3'b000;
    endcase
  endfunction

  // Control pattern: {mem_req,PCW,Adr,MW,IRW,RW,Br,ResSrc,SrcA,SrcB,ALUOp,ill,bus}
  function automatic logic [16:0] P(input logic mr, pcw, adr, mw, irw, rw, br,
                                    input logic [1:0] rs, sa, sb, aop,
                                    input logic ill, bf);
    P = {mr, pcw, adr, mw, irw, rw, br, rs, sa, sb, aop, ill, bf};
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare mid-cycle.
  task automatic step(input logic [6:0] o, input logic rdy, input logic [16:0] p,
                      input string tag);
    logic [19:0] e;
    logic [19:0] obs;
    string       t;
    op        = o;
    mem_ready = rdy;
    q_exp.push_back({p, rst_n ? imm_of(o) : 3'b000});
    q_tag.push_back(tag);
    @(negedge clk);
    obs = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Branch,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_instr, bus_fault, ImmSrc};
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  logic [16:0] pZ, pF, pFR, pD, pMA, pMR, pMW, pWB, pER, pEI, pAW, pBR, pJ, pJR0,
               pUL, pUA, pTI, pTB;

  initial begin
    pZ   = '0;
    pF   = P(1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 2'b00, 0,0);
    pFR  = P(1,1,0,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0);
    pD   = P(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0,0);
    pMA  = P(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0,0);
    pMR  = P(1,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0);
    pMW  = P(1,0,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0);
    pWB  = P(0,0,0,0,0,1,0, 2'b01, 2'b00, 2'b00, 2'b00, 0,0);
    pER  = P(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0);
    pEI  = P(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 0,0);
    pAW  = P(0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0);
    pBR  = P(0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 2'b01, 0,0);
    pJ   = P(0,1,0,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0,0);
    pJR0 = P(0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0,0);
    pUL  = P(0,0,0,0,0,0,0, 2'b00, 2'b11, 2'b01, 2'b00, 0,0);
    pUA  = P(0,0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0,0);
    pTI  = P(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1,0);
    pTB  = P(0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,1);

    rst_n     = 1'b0;
    op        = c_LW;
    mem_ready = 1'b1;
    step(c_LW, 1, pZ, "reset_all_low");
    step(c_SW, 1, pZ, "reset_all_low2");
    rst_n = 1'b1;

    // lw, zero wait states: five cycles, write-back from memory data
    step(c_LW, 1, pFR, "lw_fetch");
    step(c_LW, 1, pD,  "lw_decode");
    step(c_LW, 1, pMA, "lw_memadr");
    step(c_LW, 1, pMR, "lw_memrd");
    step(c_LW, 1, pWB, "lw_memwb");

    // sw with three wait cycles in MEMWR
    step(c_SW, 1, pFR, "sw_fetch");
    step(c_SW, 1, pD,  "sw_decode");
    step(c_SW, 1, pMA, "sw_memadr");
    for (int i = 0; i < 3; i++) step(c_SW, 0, pMW, "sw_memwr_wait");
    step(c_SW, 1, pMW, "sw_memwr_done");
    step(c_SW, 1, pFR, "sw_back_to_fetch");

    // R-type and I-type ALU
    step(c_R, 1, pD,  "r_decode");
    step(c_R, 1, pER, "r_exer");
    step(c_R, 1, pAW, "r_aluwb");
    step(c_I, 1, pFR, "i_fetch");
    step(c_I, 1, pD,  "i_decode");
    step(c_I, 1, pEI, "i_exei");
    step(c_I, 1, pAW, "i_aluwb");

    // branch
    step(c_B, 1, pFR, "b_fetch");
    step(c_B, 1, pD,  "b_decode");
    step(c_B, 1, pBR, "b_branch");

    // jal, jalr (two-phase), lui, auipc
    step(c_JAL, 1, pFR, "jal_fetch");
    step(c_JAL, 1, pD,  "jal_decode");
    step(c_JAL, 1, pJ,  "jal_jal");
    step(c_JAL, 1, pAW, "jal_aluwb");
    step(c_JALR, 1, pFR,  "jalr_fetch");
    step(c_JALR, 1, pD,   "jalr_decode");
    step(c_JALR, 1, pJR0, "jalr_phase0");
    step(c_JALR, 1, pJ,   "jalr_phase1");
    step(c_JALR, 1, pAW,  "jalr_aluwb");
    step(c_LUI, 1, pFR, "lui_fetch");
    step(c_LUI, 1, pD,  "lui_decode");
    step(c_LUI, 1, pUL, "lui_upper");
    step(c_LUI, 1, pAW, "lui_aluwb");
    step(c_AUIPC, 1, pFR, "auipc_fetch");
    step(c_AUIPC, 1, pD,  "auipc_decode");
    step(c_AUIPC, 1, pUA, "auipc_upper");
    step(c_AUIPC, 1, pAW, "auipc_aluwb");

    // illegal opcode
    step(c_BAD, 1, pFR, "ill_fetch");
    step(c_BAD, 1, pD,  "ill_decode");
    step(c_BAD, 1, pTI, "ill_trap");

    // fetch timeout: four wait cycles, TRAP on the fifth
    for (int i = 0; i < 4; i++) step(c_LW, 0, pF, "fetch_wait");
    step(c_LW, 0, pTB, "fetch_timeout_trap");
    step(c_LW, 1, pFR, "after_bus_trap_fetch");

    // MEMRD timeout
    step(c_LW, 1, pD,  "lwto_decode");
    step(c_LW, 1, pMA, "lwto_memadr");
    for (int i = 0; i < 4; i++) step(c_LW, 0, pMR, "lwto_memrd_wait");
    step(c_LW, 0, pTB, "lwto_trap");

    // asynchronous reset in the middle of a stalled store
    step(c_SW, 1, pFR, "rst_sw_fetch");
    step(c_SW, 1, pD,  "rst_sw_decode");
    step(c_SW, 1, pMA, "rst_sw_memadr");
    step(c_SW, 0, pMW, "rst_sw_memwr_wait");
    step(c_SW, 0, pMW, "rst_sw_memwr_wait2");
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    assert (MemWrite === 1'b0) else begin
      bad++;
      $error("FAIL async_rst_memwrite observed=%b expected=0", MemWrite);
    end
    total++;
    assert (mem_req === 1'b0) else begin
      bad++;
      $error("FAIL async_rst_mem_req observed=%b expected=0", mem_req);
    end
    step(c_SW, 0, pZ, "rst_hold");
    rst_n = 1'b1;
    // Counter must restart from zero: four more wait cycles before TRAP.
    for (int i = 0; i < 4; i++) step(c_SW, 0, pF, "post_rst_fetch_wait");
    step(c_SW, 0, pTB, "post_rst_timeout_trap");
    step(c_SW, 1, pFR, "post_rst_fetch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
